servo_ramp_pwm: RTL
===================

Name: servo_ramp_pwm

Overview:
- Downstream consumer of the 5 Hz clock-enable pulse in the servo steering path.
- Latches a target servo position (0..255) delivered by the SPI command decoder.
- On each 5 Hz tick, slews the current position toward the target by at most STEP units.
- Generates the 50 Hz servo PWM (1–2 ms pulse) from the current position; all logic runs on the single 100 MHz clock.

Parameters:
- PERIOD_CYC, 2000000, PWM frame length in clk cycles (20 ms at 100 MHz).
- MIN_PULSE_CYC, 100000, pulse width in cycles for position 0 (1 ms).
- UNIT_CYC, 392, additional pulse cycles per position unit (position 255 → 199960 cycles).
- STEP, 4, maximum position change per tick (1..255).
- INIT_POS, 128, current and target position after reset.
- POS_MIN, 16, lower target clamp (used only with SERVO_LIMIT_EN).
- POS_MAX, 240, upper target clamp (used only with SERVO_LIMIT_EN).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- tick_5hz  in  1  single-cycle clock-enable pulse at 5 Hz.
- target_pos  in  8  requested position.
- target_valid  in  1  single-cycle strobe; target_pos is sampled when high.
- cur_pos  out  8  current (slewed) position.
- busy  out  1  high while cur_pos != latched target.
- pwm_out  out  1  servo PWM, registered.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On reset:
  - target_q = cur_pos = INIT_POS; busy = 0; pwm_out = 0; frame counter = 0.
  - pulse_q = MIN_PULSE_CYC + INIT_POS*UNIT_CYC.
- Reset mid-frame or mid-ramp aborts immediately to the values above; there is no glitch filtering on pwm_out beyond the reset itself.
- Target latch: when target_valid = 1, target_q <= target_pos on that clock edge. A later strobe overrides an earlier one; there is no queueing.
- State machine (2-bit): HOLD, RAMP_UP, RAMP_DOWN, re-evaluated every cycle from cur_pos vs target_q.
  - HOLD: cur_pos == target_q.
  - RAMP_UP: cur_pos < target_q.
  - RAMP_DOWN: cur_pos > target_q.
- Slew on tick_5hz = 1:
  - RAMP_UP: cur_pos <= min(cur_pos+STEP, target_q).
  - RAMP_DOWN: cur_pos <= max(cur_pos−STEP, target_q).
  - HOLD: no change.
  - Arithmetic is 9-bit so there is no wrap at 0 or 255; the result never overshoots the target.
- tick_5hz and target_valid in the same cycle: the step is computed against the old target_q. The new target takes effect from the next tick.
- busy is combinational: (state != HOLD).
- Frame counter: 21-bit, counts 0..PERIOD_CYC−1 and wraps to 0.
  - At count == PERIOD_CYC−1: pulse_q <= MIN_PULSE_CYC + cur_pos*UNIT_CYC (registered multiply-add).
  - The width therefore changes only on frame boundaries, and a frame is never truncated.
- pwm_out <= (counter < pulse_q), giving one cycle of latency from counter to output.
  - The first high cycle is the first edge after reset release.
  - Pulse high time is exactly pulse_q cycles; frame period is exactly PERIOD_CYC cycles.
- Preconditions:
  - pulse_q must be < PERIOD_CYC for all positions (guaranteed by the defaults).
  - tick_5hz pulses closer together than one cycle are not defined; the upstream generator guarantees a single-cycle pulse.

Optional Feature:
- Macro SERVO_LIMIT_EN.
- Defined: target_pos is clamped to [POS_MIN, POS_MAX] before it is latched into target_q. cur_pos, and therefore the servo, never leave that range after the first tick.
- Undefined: target_pos is latched unmodified, and POS_MIN/POS_MAX are ignored.

Test Plan:
- Reset release, no stimulus (bench parameters PERIOD_CYC=1000, MIN_PULSE_CYC=100, UNIT_CYC=1) → pwm_out high 228 cycles and low 772, repeating; cur_pos=128; busy=0.
- target_valid with target_pos=140, STEP=4, then 3 ticks → cur_pos goes 132, 136, 140; busy drops after the 3rd tick; pulse_q=240 from the next frame boundary.
- target_pos=126 from cur_pos=128, STEP=4, one tick → cur_pos=126 (clamped at target, no overshoot); busy=0.
- target_valid (target_pos=200) in the same cycle as a tick with cur_pos=target_q=128 → cur_pos stays 128 on that tick; next tick → 132.
- Change cur_pos mid-frame → pwm_out width of the current frame is unchanged; the new width appears only in the following frame.
- SERVO_LIMIT_EN defined, target_pos=255 → target_q=240, and the ramp stops at cur_pos=240.
- Assert rst mid-ramp → cur_pos returns to 128 and pwm_out goes to 0 asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/servo_ramp_pwm.sv
// Servo position slew limiter and 50 Hz PWM generator.
// Optional macro SERVO_LIMIT_EN clamps incoming targets to [POS_MIN, POS_MAX].
module servo_ramp_pwm #(
    parameter int PERIOD_CYC    = 2000000,
    parameter int MIN_PULSE_CYC = 100000,
    parameter int UNIT_CYC      = 392,
    parameter int STEP          = 4,
    parameter int INIT_POS      = 128,
    parameter int POS_MIN       = 16,
    parameter int POS_MAX       = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_5hz,
    input  logic [7:0] target_pos,
    input  logic       target_valid,
    output logic [7:0] cur_pos,
    output logic       busy,
    output logic       pwm_out
);

    localparam logic [20:0] PERIOD_LAST = 21'(PERIOD_CYC - 1);
    localparam logic [20:0] MIN_P       = 21'(MIN_PULSE_CYC);
    localparam logic [20:0] UNIT_P      = 21'(UNIT_CYC);
    localparam logic [20:0] PULSE_INIT  = 21'(MIN_PULSE_CYC + INIT_POS * UNIT_CYC);
    localparam logic [8:0]  STEP9       = 9'(STEP);
    localparam logic [7:0]  INIT_P      = 8'(INIT_POS);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  cur_q, cur_d;
    logic [7:0]  tgt_in;
    logic [8:0]  up_sum, dn_diff;
    logic [20:0] cnt_q, cnt_d;
    logic [20:0] pulse_q, pulse_d;
    logic        pwm_q;

    always_comb begin
`ifdef SERVO_LIMIT_EN
        if (target_pos < 8'(POS_MIN))
            tgt_in = 8'(POS_MIN);
        else if (target_pos > 8'(POS_MAX))
            tgt_in = 8'(POS_MAX);
        else
            tgt_in = target_pos;
`else
        tgt_in = target_pos;
`endif
    end

    // Slew uses the registered target, so a strobe coincident with a tick
    // only affects the following tick.
    always_comb begin
        target_d = target_q;
        cur_d    = cur_q;
        up_sum   = {1'b0, cur_q} + STEP9;
        dn_diff  = {1'b0, cur_q} - STEP9;
        if (target_valid)
            target_d = tgt_in;
        if (tick_5hz) begin
            case (state_q)
                RAMP_UP:
                    cur_d = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[7:0];
                RAMP_DOWN:
                    cur_d = ({1'b0, cur_q} <= ({1'b0, target_q} + STEP9)) ? target_q
                                                                         : dn_diff[7:0];
                default:
                    cur_d = cur_q;
            endcase
        end
        if (cur_d == target_d)
            state_d = HOLD;
        else if (cur_d < target_d)
            state_d = RAMP_UP;
        else
            state_d = RAMP_DOWN;
    end

    always_comb begin
        cnt_d   = (cnt_q == PERIOD_LAST) ? 21'd0 : cnt_q + 21'd1;
        pulse_d = pulse_q;
        if (cnt_q == PERIOD_LAST)
            pulse_d = MIN_P + 21'(cur_q) * UNIT_P;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HOLD;
            target_q <= INIT_P;
            cur_q    <= INIT_P;
            cnt_q    <= 21'd0;
            pulse_q  <= PULSE_INIT;
            pwm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            pwm_q    <= (cnt_q < pulse_q);
        end
    end

    assign cur_pos = cur_q;
    assign busy    = (state_q != HOLD);
    assign pwm_out = pwm_q;

endmodule
